// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and padding helpers for the SHA-256 front end.
package sha256_pkg;

    localparam int unsigned SHA256_WORD_W  = 32;
    localparam int unsigned SHA256_BLOCK_W = 512;
    localparam logic [31:0] SHA256_PAD_MARKER = 32'h80000000;

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        PAD       = 3'd1,
        LEN       = 3'd2,
        EMIT      = 3'd3,
        EMIT_LAST = 3'd4
    } padder_state_e;

    // Byte counts above 4 are not legal; they are folded onto a full word.
    function automatic logic [2:0] eff_nbytes(input logic [2:0] n);
        logic [2:0] r;
        if (n > 3'd4) begin
            r = 3'd4;
        end else begin
            r = n;
        end
        return r;
    endfunction

    function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [2:0] n);
        logic [31:0] w;
        case (n)
            3'd0:    w = SHA256_PAD_MARKER;
            3'd1:    w = {data[31:24], 24'h800000};
            3'd2:    w = {data[31:16], 16'h8000};
            3'd3:    w = {data[31:8], 8'h80};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-in / block-out handshake bundle between the message source, padder and compression core.
interface sha256_padder_if;
    import sha256_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [SHA256_WORD_W-1:0]  in_data;
    logic                      in_last;
    logic [2:0]                in_nbytes;
    logic                      blk_valid;
    logic                      blk_ready;
    logic [SHA256_BLOCK_W-1:0] blk_data;
    logic                      blk_first;
    logic                      blk_last;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last
    );

endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects big-endian words into a 16-word buffer, appends the
// 0x80 marker, zero fill and 64-bit bit length, and presents whole 512-bit blocks.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    sha256_padder_if.slave bus
);

    padder_state_e state_q, state_d;
    logic [3:0]    widx_q, widx_d;
    logic [60:0]   count_q, count_d;
    logic          first_q, first_d;
    logic          marker_q, marker_d;
    logic          extra_q, extra_d;

    logic          in_ready_q;
    logic          blk_valid_q;
    logic          blk_first_q;
    logic          blk_last_q;

    logic [31:0]   mem_q [16];
    logic          wr_en_s;
    logic          wr_len_s;
    logic [3:0]    wr_addr_s;
    logic [31:0]   wr_data_s;
    logic [2:0]    nbytes_eff_s;
    logic [63:0]   bit_len_s;
    logic [SHA256_BLOCK_W-1:0] blk_data_s;
    logic          emit_d_s;

    assign nbytes_eff_s = eff_nbytes(bus.in_nbytes);
    assign bit_len_s    = {count_q, 3'b000};
    assign emit_d_s     = (state_d == EMIT) || (state_d == EMIT_LAST);

    // Next-state and buffer write selection for the padding FSM.
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        count_d   = count_q;
        first_d   = first_q;
        marker_d  = marker_q;
        extra_d   = extra_q;
        wr_en_s   = 1'b0;
        wr_len_s  = 1'b0;
        wr_addr_s = widx_q;
        wr_data_s = 32'h00000000;
        case (state_q)
            FILL: begin
                if (bus.in_valid && in_ready_q) begin
                    wr_en_s = 1'b1;
                    widx_d  = widx_q + 4'd1;
                    if (bus.in_last) begin
                        wr_data_s = pad_last_word(bus.in_data, nbytes_eff_s);
                        count_d   = count_q + {58'd0, nbytes_eff_s};
                        marker_d  = (nbytes_eff_s == 3'd4);
                        if (widx_q == 4'd15) begin
                            extra_d = 1'b1;
                            state_d = EMIT;
                        end else if ((widx_q == 4'd13) && (nbytes_eff_s != 3'd4)) begin
                            state_d = LEN;
                        end else begin
                            state_d = PAD;
                        end
                    end else begin
                        wr_data_s = bus.in_data;
                        count_d   = count_q + 61'd4;
                        if (widx_q == 4'd15) begin
                            state_d = EMIT;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end else begin
                    state_d = FILL;
                end
            end
            PAD: begin
                if ((widx_q == 4'd14) && !marker_q) begin
                    state_d = LEN;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_data_s = marker_q ? SHA256_PAD_MARKER : 32'h00000000;
                    marker_d  = 1'b0;
                    widx_d    = widx_q + 4'd1;
                    // Word 13 written means words 14/15 are free for the length next cycle.
                    if (widx_q == 4'd15) begin
                        extra_d = 1'b1;
                        state_d = EMIT;
                    end else if (widx_q == 4'd13) begin
                        state_d = LEN;
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            LEN: begin
                wr_len_s = 1'b1;
                state_d  = EMIT_LAST;
            end
            EMIT: begin
                if (blk_valid_q && bus.blk_ready) begin
                    widx_d  = 4'd0;
                    first_d = 1'b0;
                    extra_d = 1'b0;
                    if (extra_q || marker_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT_LAST: begin
                if (blk_valid_q && bus.blk_ready) begin
                    widx_d   = 4'd0;
                    count_d  = 61'd0;
                    first_d  = 1'b1;
                    extra_d  = 1'b0;
                    marker_d = 1'b0;
                    state_d  = FILL;
                end else begin
                    state_d = EMIT_LAST;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // FSM state, counters and registered handshake/flag outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            widx_q      <= 4'd0;
            count_q     <= 61'd0;
            first_q     <= 1'b1;
            marker_q    <= 1'b0;
            extra_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            count_q     <= count_d;
            first_q     <= first_d;
            marker_q    <= marker_d;
            extra_q     <= extra_d;
            in_ready_q  <= (state_d == FILL);
            blk_valid_q <= emit_d_s;
            blk_first_q <= emit_d_s ? first_d : 1'b0;
            blk_last_q  <= (state_d == EMIT_LAST);
        end
    end

    // Block buffer; blk_data is a direct view of it, so it is cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 32'h00000000;
            end
        end else if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end else if (wr_len_s) begin
            mem_q[14] <= bit_len_s[63:32];
            mem_q[15] <= bit_len_s[31:0];
        end
    end

    // Word 0 lands in the most significant slice of the block.
    always_comb begin
        blk_data_s = '0;
        for (int i = 0; i < 16; i++) begin
            blk_data_s[SHA256_BLOCK_W-1-32*i -: 32] = mem_q[i];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_data  = blk_data_s;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;

endmodule
